// File: rtl/scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | scan_pkg : shared state encoding and 7-segment glyph table for the digit    |
// |            scan controller (segments gfedcba, active-low, bit0 = a).        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry n is the glyph for hex value n; b and d use lowercase shapes.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage
`default_nettype wire

// File: rtl/digit_scan_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | digit_scan_ctrl_if : value inputs and display-pin outputs of the scanner.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface digit_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);
  localparam int IDX_W = $clog2(N_DIGITS);

  logic                  i_enable;
  logic [4*N_DIGITS-1:0] i_digits;
  logic [N_DIGITS-1:0]   i_dp;
  logic [IDX_W-1:0]      o_ctrl;
  logic [N_DIGITS-1:0]   o_digitSelect;
  logic [6:0]            o_segments;
  logic                  o_dp;
  logic                  o_frame;

  modport master (
    output i_enable, i_digits, i_dp,
    input  o_ctrl, o_digitSelect, o_segments, o_dp, o_frame
  );

  modport slave (
    input  i_enable, i_digits, i_dp,
    output o_ctrl, o_digitSelect, o_segments, o_dp, o_frame
  );

endinterface
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_decode : combinational hex nibble to active-low 7-segment decoder.     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module seg7_decode
  import scan_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule
`default_nettype wire

// File: rtl/digit_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | digit_scan_ctrl : N-digit multiplexed 7-segment scanner with dead time and  |
// |                   frame strobe. Define SCAN_LZB_EN for leading-zero blank.  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int TICK_DIV     = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  digit_scan_ctrl_if.slave bus
);

  localparam int IDX_W   = $clog2(N_DIGITS);
  localparam int CNT_MAX = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_DIGITS - 1);
  localparam scan_state_e      c_after_on = (BLANK_CYCLES == 0) ? ST_ON : ST_BLANK;

  scan_state_e         r_state, w_state_n;
  logic [CNT_W-1:0]    r_cnt,   w_cnt_n;
  logic [IDX_W-1:0]    r_idx,   w_idx_n;
  logic                w_frame_n;
  logic                w_on_n;
  logic [3:0]          w_nibble;
  logic [6:0]          w_dec;
  logic                w_lzb;

  logic [IDX_W-1:0]    r_ctrl;
  logic [N_DIGITS-1:0] r_sel;
  logic [6:0]          r_seg;
  logic                r_dp;
  logic                r_frame;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_frame_n = 1'b0;
    if (!bus.i_enable) begin
      w_state_n = ST_IDLE;
      w_cnt_n   = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_n = c_after_on;
          w_cnt_n   = '0;
        end
        ST_BLANK: begin
          if (int'(r_cnt) >= BLANK_CYCLES - 1) begin
            w_state_n = ST_ON;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt + CNT_W'(1);
          end
        end
        ST_ON: begin
          if (int'(r_cnt) >= TICK_DIV - 1) begin
            w_state_n = c_after_on;
            w_cnt_n   = '0;
            if (r_idx == c_last_idx) begin
              w_idx_n   = '0;
              w_frame_n = 1'b1;
            end else begin
              w_idx_n = r_idx + IDX_W'(1);
            end
          end else begin
            w_cnt_n = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_n = ST_IDLE;
          w_cnt_n   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the state being entered so they line up with it.
  assign w_on_n   = (w_state_n == ST_ON);
  assign w_nibble = bus.i_digits[{w_idx_n, 2'b00} +: 4];

  seg7_decode u_dec (
    .nibble (w_nibble),
    .seg    (w_dec)
  );

`ifdef SCAN_LZB_EN
  logic [N_DIGITS-1:0] w_upper_zero;
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_lzb
    if (k == N_DIGITS - 1) begin : g_top
      assign w_upper_zero[k] = (bus.i_digits[4*k +: 4] == 4'h0);
    end else begin : g_mid
      assign w_upper_zero[k] = (bus.i_digits[4*k +: 4] == 4'h0) && w_upper_zero[k+1];
    end
  end
  assign w_lzb = (w_idx_n != '0) && w_upper_zero[w_idx_n];
`else
  assign w_lzb = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ctrl  <= '0;
      r_sel   <= '1;
      r_seg   <= SEG_OFF;
      r_dp    <= 1'b1;
      r_frame <= 1'b0;
    end else begin
      r_ctrl  <= w_idx_n;
      r_sel   <= w_on_n ? ~(N_DIGITS'(1) << w_idx_n) : '1;
      r_seg   <= (w_on_n && !w_lzb) ? w_dec : SEG_OFF;
      r_dp    <= w_on_n ? ~bus.i_dp[w_idx_n] : 1'b1;
      r_frame <= w_frame_n;
    end
  end

  assign bus.o_ctrl        = r_ctrl;
  assign bus.o_digitSelect = r_sel;
  assign bus.o_segments    = r_seg;
  assign bus.o_dp          = r_dp;
  assign bus.o_frame       = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_digit_scan_ctrl : self-checking bench for digit_scan_ctrl (4/4/1, 6/1/0) |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_digit_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2;

  digit_scan_ctrl_if #(.N_DIGITS(4)) bus1 ();
  digit_scan_ctrl_if #(.N_DIGITS(6)) bus2 ();

  digit_scan_ctrl #(.N_DIGITS(4), .TICK_DIV(4), .BLANK_CYCLES(1)) dut1 (
    .i_clk (clk),
    .i_rst (rst1),
    .bus   (bus1)
  );

  digit_scan_ctrl #(.N_DIGITS(6), .TICK_DIV(1), .BLANK_CYCLES(0)) dut2 (
    .i_clk (clk),
    .i_rst (rst2),
    .bus   (bus2)
  );

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [6:0]  seg [4];
  } vec_t;

  typedef struct {
    logic [1:0] ctrl;
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
  } exp_t;

  vec_t       vecs [5];
  exp_t       sb   [$];
  logic [6:0] seg_ref [16];

  int checks = 0;
  int errors = 0;
  int cur;
  int p;
  int held;
  bit first;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  // Position model: p walks 0..19 through a frame, 5 cycles per digit, first one blank.
  task automatic predict();
    exp_t e;
    int d, w;
    e.ctrl = 2'd0; e.sel = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.frame = 1'b0;
    if (rst1) begin
      p = 0; first = 1'b1; held = 0;
    end else if (!bus1.i_enable) begin
      e.ctrl = held[1:0];
      p = held * 5;
      first = 1'b1;
    end else begin
      d = p / 5;
      w = p % 5;
      e.ctrl  = d[1:0];
      e.frame = (p == 0) && !first;
      if (w != 0) begin
        e.sel = ~(4'(1) << d);
        e.seg = vecs[cur].seg[d];
        e.dp  = ~vecs[cur].dp[d];
      end
      first = 1'b0;
      held  = d;
      p     = (p + 1) % 20;
    end
    sb.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    predict();
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("ctrl",   32'(bus1.o_ctrl),        32'(e.ctrl));
      check("select", 32'(bus1.o_digitSelect), 32'(e.sel));
      check("seg",    32'(bus1.o_segments),    32'(e.seg));
      check("dp",     32'(bus1.o_dp),          32'(e.dp));
      check("frame",  32'(bus1.o_frame),       32'(e.frame));
    end
  endtask

  task automatic apply_vec(input int v);
    cur = v;
    bus1.i_digits = vecs[v].digits;
    bus1.i_dp     = vecs[v].dp;
  endtask

  initial begin
    seg_ref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    vecs[0].digits = 16'h3A70; vecs[0].dp = 4'b0100; vecs[0].seg = '{7'h40, 7'h78, 7'h08, 7'h30};
    vecs[1].digits = 16'hFEDC; vecs[1].dp = 4'b1010; vecs[1].seg = '{7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[2].digits = 16'h9821; vecs[2].dp = 4'b0001; vecs[2].seg = '{7'h79, 7'h24, 7'h00, 7'h10};
    vecs[3].digits = 16'h6B45; vecs[3].dp = 4'b1111; vecs[3].seg = '{7'h12, 7'h19, 7'h03, 7'h02};
`ifdef SCAN_LZB_EN
    vecs[4].digits = 16'h0050; vecs[4].dp = 4'b1000; vecs[4].seg = '{7'h40, 7'h12, 7'h7F, 7'h7F};
`else
    vecs[4].digits = 16'h0050; vecs[4].dp = 4'b1000; vecs[4].seg = '{7'h40, 7'h12, 7'h40, 7'h40};
`endif

    rst1 = 1'b1;
    rst2 = 1'b1;
    bus1.i_enable = 1'b1;
    apply_vec(0);
    bus2.i_enable = 1'b0;
    bus2.i_digits = 24'h543210;
    bus2.i_dp     = 6'b000000;
    p = 0; first = 1'b1; held = 0;
    @(negedge clk);

    repeat (3) step();
    rst1 = 1'b0;

    for (int v = 0; v < 5; v++) begin
      apply_vec(v);
      repeat (20) step();
    end

    // Drop enable while digit 2 is mid-dwell, then resume.
    apply_vec(0);
    for (int i = 0; i < 20 && p != 13; i++) step();
    bus1.i_enable = 1'b0;
    repeat (2) step();
    bus1.i_enable = 1'b1;
    repeat (7) step();

    // Reset while digit 3 is lit; scan must restart from digit 0.
    for (int i = 0; i < 20 && p != 17; i++) step();
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    repeat (8) step();

    // Six digits, no dead time, one cycle per digit.
    check("n6_reset_select", 32'(bus2.o_digitSelect), 32'h3F);
    check("n6_reset_ctrl",   32'(bus2.o_ctrl),        32'h0);
    bus2.i_enable = 1'b1;
    rst2 = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      int idx;
      logic [5:0] want_sel;
      idx = (k - 1) % 6;
      want_sel = ~(6'(1) << idx);
      @(posedge clk);
      @(negedge clk);
      check("n6_ctrl",    32'(bus2.o_ctrl),        32'(idx));
      check("n6_frame",   32'(bus2.o_frame),       32'((k > 1) && (idx == 0)));
      check("n6_select",  32'(bus2.o_digitSelect), 32'(want_sel));
      check("n6_onehot",  32'($countones(~bus2.o_digitSelect)), 32'd1);
      check("n6_seg",     32'(bus2.o_segments),    32'(seg_ref[idx]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
`default_nettype wire
